data_mem_unit: RTL and testbench

- Data-memory access block for the MEM stage of the 5-stage RV64 pipeline.
- Sits between the EX/MEM and MEM/WB pipeline registers.
- Holds a doubleword-organised RAM with synchronous byte-lane writes and combinational reads.
- Read data is extracted by access size and extended by a select code before it is registered into MEM/WB.

---
 rtl/data_mem_unit.sv | 149 ++++++++++++++
 tb/tb_data_mem_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage data memory for the RV64 pipeline.
// This is a doubleword-wide array. Stores are synchronous and write only the
// selected byte lanes. Loads are combinational and are extended by sel_memdata.
// Each access is forced to natural alignment by ignoring the low address bits.
// Optional feature macro: DATA_MEM_ERR_EN adds the combinational 'err' output.
// It flags accesses that are out of range, have a non-one-hot mask, or are misaligned.
// The array clears asynchronously on reset, so it maps to flops rather than block RAM.

module data_mem_unit #(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        wen,
    input  logic [3:0]  mem_mask,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [1:0]  sel_memdata,
    output logic [63:0] rdata
`ifdef DATA_MEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Doubleword offset from the base.
    // The base is assumed to be 8-byte aligned, so the lane bits come straight from addr.
    logic [60:0]      offset_dw;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             is_b, is_h, is_w, is_d, mask_ok;
    logic             acc_ok, wr_en, rd_en;
    logic [2:0]       lane_off;
    logic [7:0]       be;
    logic [63:0]      wr_data;
    logic [63:0]      rd_entry;
    logic [63:0]      lane;
    logic [63:0]      rdata_next;
    logic [63:0]      ent_q [DEPTH];

    assign offset_dw = addr[63:3] - ADDR_BASE[63:3];
    assign idx       = offset_dw[IDX_W-1:0];
    assign in_range  = (addr >= ADDR_BASE) && (offset_dw < 61'(DEPTH));

    assign is_b    = (mem_mask == 4'b0001);
    assign is_h    = (mem_mask == 4'b0010);
    assign is_w    = (mem_mask == 4'b0100);
    assign is_d    = (mem_mask == 4'b1000);
    assign mask_ok = is_b | is_h | is_w | is_d;

    // Reset also gates the datapath, so rdata and writes are suppressed while rst=0.
    assign acc_ok = rst && ena && in_range && mask_ok;
    assign wr_en  = acc_ok && wen;
    assign rd_en  = acc_ok && !wen;

    // Aligned byte offset, byte enables and lane-replicated store data by access size.
    always_comb begin
        lane_off = 3'd0;
        be       = 8'h00;
        wr_data  = wdata;
        if (is_b) begin
            lane_off = addr[2:0];
            be       = 8'h01 << addr[2:0];
            wr_data  = {8{wdata[7:0]}};
        end else if (is_h) begin
            lane_off = {addr[2:1], 1'b0};
            be       = 8'h03 << {addr[2:1], 1'b0};
            wr_data  = {4{wdata[15:0]}};
        end else if (is_w) begin
            lane_off = {addr[2], 2'b00};
            be       = 8'h0F << {addr[2], 2'b00};
            wr_data  = {2{wdata[31:0]}};
        end else if (is_d) begin
            lane_off = 3'd0;
            be       = 8'hFF;
            wr_data  = wdata;
        end
    end

    // One register per entry. Each entry updates only the enabled byte lanes when it is addressed.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [63:0] entry_reg;
        logic        hit;

        assign hit = wr_en && (idx == IDX_W'(gi));

        // Asynchronous clear and byte-lane write for this entry.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg <= '0;
            end else if (hit) begin
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) begin
                        entry_reg[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end

        assign ent_q[gi] = entry_reg;
    end

    assign rd_entry = ent_q[idx];
    assign lane     = rd_entry >> {lane_off, 3'b000};

    // Load extension: sel 00 sign-extends; 01 and 1x zero-extend; doubleword ignores sel.
    always_comb begin
        rdata_next = '0;
        if (rd_en) begin
            if (is_b) begin
                rdata_next = (sel_memdata == 2'b00) ? {{56{lane[7]}}, lane[7:0]}
                                                    : {56'd0, lane[7:0]};
            end else if (is_h) begin
                rdata_next = (sel_memdata == 2'b00) ? {{48{lane[15]}}, lane[15:0]}
                                                    : {48'd0, lane[15:0]};
            end else if (is_w) begin
                rdata_next = (sel_memdata == 2'b00) ? {{32{lane[31]}}, lane[31:0]}
                                                    : {32'd0, lane[31:0]};
            end else begin
                rdata_next = lane;
            end
        end
    end

    assign rdata = rdata_next;

`ifdef DATA_MEM_ERR_EN
    logic misalign;

    // Low address bits that natural alignment would discard for this access size.
    always_comb begin
        misalign = 1'b0;
        if (is_h) begin
            misalign = addr[0];
        end else if (is_w) begin
            misalign = |addr[1:0];
        end else if (is_d) begin
            misalign = |addr[2:0];
        end
    end

    assign err = rst && ena && (!in_range || !mask_ok || misalign);
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Table-driven bench for data_mem_unit, plus hand-written reset sequences.
// Inputs are driven on the falling edge, and outputs are sampled 1 time unit later.
// Stores commit on the following rising edge.
// With DATA_MEM_ERR_EN defined, the bench also checks err.

module tb_data_mem_unit;

    localparam logic [3:0] MB = 4'b0001;
    localparam logic [3:0] MH = 4'b0010;
    localparam logic [3:0] MW = 4'b0100;
    localparam logic [3:0] MD = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wen;
    logic [3:0]  mem_mask;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  sel_memdata;
    logic [63:0] rdata;
`ifdef DATA_MEM_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ena;
        logic        wen;
        logic [3:0]  mask;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  sel;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    data_mem_unit dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .wen(wen),
        .mem_mask(mem_mask),
        .addr(addr),
        .wdata(wdata),
        .sel_memdata(sel_memdata),
        .rdata(rdata)
`ifdef DATA_MEM_ERR_EN
        ,
        .err(err)
`endif
    );

    function automatic void add(input logic e, input logic w, input logic [3:0] m,
                                input logic [63:0] a, input logic [63:0] d,
                                input logic [1:0] s, input logic [63:0] x,
                                input logic xe);
        vec_t v;
        v.ena = e; v.wen = w; v.mask = m; v.addr = a; v.wdata = d;
        v.sel = s; v.exp_rdata = x; v.exp_err = xe;
        vecs.push_back(v);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check_err(input string name, input logic exp);
`ifdef DATA_MEM_ERR_EN
        checks++;
        if (err !== exp) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", name, err, exp);
        end
`else
        if (exp === 1'bx) $display("unreachable %s", name);
`endif
    endtask

    task automatic drive(input logic e, input logic w, input logic [3:0] m,
                         input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        ena = e; wen = w; mem_mask = m; addr = a; wdata = d; sel_memdata = s;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b0, MD, 64'h8000_0000, 64'd0, 2'b00);

        // ena wen mask addr wdata sel expected_rdata expected_err
        add(1,0,MD,64'h8000_0000,64'd0,2'b00,64'h0,0);
        add(1,1,MD,64'h8000_0008,64'h8877665544332211,2'b00,64'h0,0);
        add(1,0,MD,64'h8000_0008,64'd0,2'b00,64'h8877665544332211,0);
        add(1,0,MB,64'h8000_000F,64'd0,2'b00,64'hFFFFFFFFFFFFFF88,0);
        add(1,0,MB,64'h8000_000F,64'd0,2'b01,64'h88,0);
        add(1,0,MB,64'h8000_0008,64'd0,2'b10,64'h11,0);
        add(1,0,MH,64'h8000_000E,64'd0,2'b11,64'h8877,0);
        add(1,0,MH,64'h8000_000E,64'd0,2'b00,64'hFFFFFFFFFFFF8877,0);
        add(1,0,MW,64'h8000_000C,64'd0,2'b00,64'hFFFFFFFF88776655,0);
        add(1,0,MW,64'h8000_000C,64'd0,2'b01,64'h0000000088776655,0);
        add(1,0,MD,64'h8000_0008,64'd0,2'b01,64'h8877665544332211,0);
        add(1,0,MD,64'h8000_000D,64'd0,2'b00,64'h8877665544332211,1);
        add(1,1,MH,64'h8000_0002,64'h1234_0000_0000_BEEF,2'b00,64'h0,0);
        add(1,0,MD,64'h8000_0000,64'd0,2'b00,64'h00000000BEEF0000,0);
        add(1,0,MW,64'h8000_0000,64'd0,2'b00,64'hFFFFFFFFBEEF0000,0);
        add(1,0,MW,64'h8000_0000,64'd0,2'b01,64'h00000000BEEF0000,0);
        add(1,1,MB,64'h8000_0001,64'hFFFF_FFFF_FFFF_FF7F,2'b00,64'h0,0);
        add(1,0,MB,64'h8000_0001,64'd0,2'b00,64'h7F,0);
        add(1,0,MH,64'h8000_0003,64'd0,2'b01,64'hBEEF,1);
        add(1,0,MH,64'h8000_0002,64'd0,2'b00,64'hFFFFFFFFFFFFBEEF,0);
        add(1,0,MH,64'h8000_0001,64'd0,2'b00,64'h7F00,1);
        add(1,1,MD,64'h8000_0010,64'hAAAAAAAAAAAAAAAA,2'b00,64'h0,0);
        add(1,1,MW,64'h8000_0014,64'hDEADBEEF12345678,2'b00,64'h0,0);
        add(1,0,MD,64'h8000_0010,64'd0,2'b00,64'h12345678AAAAAAAA,0);
        add(1,1,MW,64'h8000_0017,64'h0000_0000_0BAD_F00D,2'b00,64'h0,1);
        add(1,0,MD,64'h8000_0010,64'd0,2'b00,64'h0BADF00DAAAAAAAA,0);
        add(1,0,MD,64'h8000_07F8,64'd0,2'b00,64'h0,0);
        add(1,1,MD,64'h8000_07F8,64'h0123456789ABCDEF,2'b00,64'h0,0);
        add(1,1,MD,64'h7FFF_FFF8,64'h1111111111111111,2'b00,64'h0,1);
        add(1,1,MD,64'h8000_0800,64'h2222222222222222,2'b00,64'h0,1);
        add(1,0,MD,64'h7FFF_FFF8,64'd0,2'b00,64'h0,1);
        add(1,0,MD,64'h8000_0800,64'd0,2'b00,64'h0,1);
        add(1,0,MD,64'h8000_07F8,64'd0,2'b00,64'h0123456789ABCDEF,0);
        add(1,0,MD,64'h8000_0000,64'd0,2'b00,64'h00000000BEEF7F00,0);
        add(1,1,4'b0011,64'h8000_0000,64'hFFFFFFFFFFFFFFFF,2'b00,64'h0,1);
        add(1,0,4'b0011,64'h8000_0000,64'd0,2'b01,64'h0,1);
        add(1,0,MD,64'h8000_0000,64'd0,2'b00,64'h00000000BEEF7F00,0);
        add(0,1,MD,64'h8000_0000,64'h5555555555555555,2'b00,64'h0,0);
        add(0,0,MD,64'h8000_0000,64'd0,2'b00,64'h0,0);
        add(1,0,MD,64'h8000_0000,64'd0,2'b00,64'h00000000BEEF7F00,0);

        // Reset held: even an enabled load must read 0.
        repeat (3) @(negedge clk);
        #1;
        check64("in_reset_rdata", rdata, 64'h0);
        check_err("in_reset", 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ena, vecs[i].wen, vecs[i].mask, vecs[i].addr,
                  vecs[i].wdata, vecs[i].sel);
            #1;
            $display("vec%0d ena=%b wen=%b mask=%b addr=%h wdata=%h sel=%b rdata=%h",
                     i, vecs[i].ena, vecs[i].wen, vecs[i].mask, vecs[i].addr,
                     vecs[i].wdata, vecs[i].sel, rdata);
            check64($sformatf("vec%0d", i), rdata, vecs[i].exp_rdata);
            check_err($sformatf("vec%0d", i), vecs[i].exp_err);
        end

        // Mid-run reset: store, confirm, then assert rst within a cycle.
        @(negedge clk);
        drive(1, 1, MD, 64'h8000_0020, 64'hCAFEF00D12345678, 2'b00);
        @(negedge clk);
        drive(1, 0, MD, 64'h8000_0020, 64'd0, 2'b00);
        #1;
        check64("raw_before_reset", rdata, 64'hCAFEF00D12345678);
        #1;
        rst = 1'b0;
        #1;
        $display("mid-run reset asserted rdata=%h", rdata);
        check64("async_reset_rdata", rdata, 64'h0);
        check_err("async_reset", 1'b0);

        // Release rst and store on the very first edge with rst=1.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, MD, 64'h8000_0030, 64'h0F0F0F0F0F0F0F0F, 2'b00);
        #1;
        check64("first_edge_store_cycle", rdata, 64'h0);
        @(negedge clk);
        drive(1, 0, MD, 64'h8000_0030, 64'd0, 2'b00);
        #1;
        check64("first_edge_store_read", rdata, 64'h0F0F0F0F0F0F0F0F);
        @(negedge clk);
        drive(1, 0, MD, 64'h8000_0020, 64'd0, 2'b00);
        #1;
        check64("cleared_entry4", rdata, 64'h0);
        @(negedge clk);
        drive(1, 0, MD, 64'h8000_0008, 64'd0, 2'b00);
        #1;
        check64("cleared_entry1", rdata, 64'h0);
        @(negedge clk);
        drive(1, 0, MD, 64'h8000_07F8, 64'd0, 2'b00);
        #1;
        check64("cleared_last", rdata, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
